scmips_periph_ctrl: RTL and testbench

Memory-mapped peripheral controller for the single-cycle MIPS core (SCMIPS). It sits on the core's data-memory bus at BASE_ADDR and owns the board resources: 8 switches, 8 LEDs and four 7-segment digits. It also contains a reloadable interval timer that raises an interrupt request to the core. Reads are combinational so that the single-cycle core can complete a load in one cycle; writes commit on the clock edge.

---
 rtl/scmips_periph_pkg.sv | 36 +++
 rtl/scmips_periph_ctrl_seg7_decode.sv | 11 +
 rtl/scmips_periph_ctrl.sv | 130 +++++++++++++
 tb/tb_scmips_periph_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/scmips_periph_pkg.sv
// Shared definitions for the SCMIPS peripheral controller: register map,
// TCON bit positions and the active-low hex-to-7-segment table.
package scmips_periph_pkg;

  typedef logic [4:0] reg_off_t;

  localparam reg_off_t OFF_TH      = 5'h00;
  localparam reg_off_t OFF_TL      = 5'h04;
  localparam reg_off_t OFF_TCON    = 5'h08;
  localparam reg_off_t OFF_LED     = 5'h0C;
  localparam reg_off_t OFF_SW      = 5'h10;
  localparam reg_off_t OFF_DIGI    = 5'h14;
  localparam reg_off_t OFF_SYSTICK = 5'h18;

  // One past the last mapped byte offset of the register window.
  localparam logic [31:0] WINDOW_BYTES = 32'h0000_001C;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;

  // Segment bit order {g,f,e,d,c,b,a}, active-low.
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic seg7_t hex_to_seg7(input logic [3:0] hex);
    return SEG7_TABLE[hex];
  endfunction

endpackage

// File: rtl/scmips_periph_ctrl_seg7_decode.sv
// Single hex digit to active-low 7-segment pattern.
module seg7_decode
  import scmips_periph_pkg::*;
(
  input  logic [3:0] hex,
  output seg7_t      seg
);

  assign seg = hex_to_seg7(hex);

endmodule

// File: rtl/scmips_periph_ctrl.sv
// Memory-mapped peripheral controller for SCMIPS: switches, LEDs, four
// 7-segment digits and an interval timer with IRQ. Optional free-running
// SYSTICK counter is enabled by defining SCMIPS_SYSTICK_EN.
module scmips_periph_ctrl
  import scmips_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [6:0]  digi_out1,
  output logic [6:0]  digi_out2,
  output logic [6:0]  digi_out3,
  output logic [6:0]  digi_out4,
  output logic        irq
);

  localparam logic [31:0] DIV_LAST  = 32'(TIMER_DIV - 1);
  localparam logic [31:0] BASE_WORD = BASE_ADDR & 32'hFFFF_FFFC;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [7:0]  led_reg;
  logic [15:0] digi;
  logic [31:0] presc;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [31:0] systick_val;

  logic [31:0] rel;
  logic        hit;
  reg_off_t    off;
  logic        wr_hit;
  logic        tick;
  logic        tl_full;
  logic        wr_tl;
  logic        ovf_set;

  // Byte-lane bits are dropped before the window compare.
  assign rel    = (mem_addr & 32'hFFFF_FFFC) - BASE_WORD;
  assign hit    = (rel < WINDOW_BYTES);
  assign off    = rel[4:0];
  assign wr_hit = mem_wr && hit;

  assign tick    = tcon[TCON_EN] && (presc == DIV_LAST);
  assign tl_full = (tl == '1);
  assign wr_tl   = wr_hit && (off == OFF_TL);
  // A CPU write to TL in the same cycle discards the overflow entirely.
  assign ovf_set = tick && tl_full && tcon[TCON_IE] && !wr_tl;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led_reg <= '0;
      digi    <= '0;
      presc   <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;

      if (tcon[TCON_EN]) presc <= tick ? '0 : presc + 32'd1;

      if (wr_tl)     tl <= mem_wdata;
      else if (tick) tl <= tl_full ? th : tl + 32'd1;

      if (wr_hit && off == OFF_TH)   th      <= mem_wdata;
      if (wr_hit && off == OFF_LED)  led_reg <= mem_wdata[7:0];
      if (wr_hit && off == OFF_DIGI) digi    <= mem_wdata[15:0];

      if (wr_hit && off == OFF_TCON) begin
        tcon[TCON_EN] <= mem_wdata[TCON_EN];
        tcon[TCON_IE] <= mem_wdata[TCON_IE];
        tcon[TCON_ST] <= mem_wdata[TCON_ST] | ovf_set;
      end else if (ovf_set) begin
        tcon[TCON_ST] <= 1'b1;
      end
    end
  end

`ifdef SCMIPS_SYSTICK_EN
  logic [31:0] systick;

  always_ff @(posedge sysclk) begin
    if (reset) systick <= '0;
    else       systick <= systick + 32'd1;
  end

  assign systick_val = systick;
`else
  assign systick_val = '0;
`endif

  always_comb begin
    mem_rdata = '0;
    if (mem_rd && hit) begin
      case (off)
        OFF_TH:      mem_rdata = th;
        OFF_TL:      mem_rdata = tl;
        OFF_TCON:    mem_rdata = {29'd0, tcon};
        OFF_LED:     mem_rdata = {24'd0, led_reg};
        OFF_SW:      mem_rdata = {24'd0, sw_sync};
        OFF_DIGI:    mem_rdata = {16'd0, digi};
        OFF_SYSTICK: mem_rdata = systick_val;
        default:     mem_rdata = '0;
      endcase
    end
  end

  assign led = led_reg;
  assign irq = tcon[TCON_ST] & tcon[TCON_IE];

  seg7_decode u_dig1 (.hex(digi[3:0]),   .seg(digi_out1));
  seg7_decode u_dig2 (.hex(digi[7:4]),   .seg(digi_out2));
  seg7_decode u_dig3 (.hex(digi[11:8]),  .seg(digi_out3));
  seg7_decode u_dig4 (.hex(digi[15:12]), .seg(digi_out4));

endmodule

// File: tb/tb_scmips_periph_ctrl.sv
// Directed self-checking bench for scmips_periph_ctrl (TIMER_DIV=1).
module tb_scmips_periph_ctrl;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [6:0]  digi_out1, digi_out2, digi_out3, digi_out4;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sysclk = ~sysclk;

  scmips_periph_ctrl #(.BASE_ADDR(B), .TIMER_DIV(1)) dut (
    .sysclk(sysclk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .switch(switch), .led(led), .digi_out1(digi_out1), .digi_out2(digi_out2),
    .digi_out3(digi_out3), .digi_out4(digi_out4), .irq(irq)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; leaves time at the next falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_wr    = 1'b1;
    @(posedge sysclk);
    #1;
    mem_wr = 1'b0;
    @(negedge sysclk);
  endtask

  // Combinational read sampled mid-low-phase; does not advance a cycle.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    mem_rd   = 1'b1;
    #1;
    d = mem_rdata;
    mem_rd = 1'b0;
  endtask

  task automatic tick();
    @(negedge sysclk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] rd2;
    int          n;

    vecs[0]  = '{"led_rw",      B + 32'h0C, 1'b1, 32'h0000_00A5, 32'h0000_00A5};
    vecs[1]  = '{"digi_rw",     B + 32'h14, 1'b1, 32'hFFFF_10AF, 32'h0000_10AF};
    vecs[2]  = '{"th_rw",       B + 32'h00, 1'b1, 32'h1234_5678, 32'h1234_5678};
    vecs[3]  = '{"sw_ro",       B + 32'h10, 1'b1, 32'h0000_00FF, 32'h0000_0000};
    vecs[4]  = '{"unmapped_1c", B + 32'h1C, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[5]  = '{"led_lowbits", B + 32'h0E, 1'b0, 32'h0,         32'h0000_00A5};
    vecs[6]  = '{"tcon_mask",   B + 32'h08, 1'b1, 32'hFFFF_FFFA, 32'h0000_0002};
    vecs[7]  = '{"tcon_clear",  B + 32'h08, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[8]  = '{"below_base",  B - 32'h04, 1'b0, 32'h0,         32'h0000_0000};
    vecs[9]  = '{"tl_rw",       B + 32'h04, 1'b1, 32'h0000_BEEF, 32'h0000_BEEF};
    vecs[10] = '{"past_window", B + 32'h20, 1'b0, 32'h0,         32'h0000_0000};

    reset = 1'b1; mem_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_wdata = '0; switch = '0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    reset = 1'b0;
    tick();

    check("rst_led", {24'd0, led}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_dig1", {25'd0, digi_out1}, 32'h40);
    check("rst_dig4", {25'd0, digi_out4}, 32'h40);
    bus_read(B + 32'h08, rd); check("rst_tcon", rd, 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end

    check("led_out", {24'd0, led}, 32'h0000_00A5);
    check("dig1_F", {25'd0, digi_out1}, 32'h0E);
    check("dig2_A", {25'd0, digi_out2}, 32'h08);
    check("dig3_0", {25'd0, digi_out3}, 32'h40);
    check("dig4_1", {25'd0, digi_out4}, 32'h79);
    mem_addr = B + 32'h0C; mem_rd = 1'b0; #1;
    check("rd_strobe_low", mem_rdata, 32'h0);

    switch = 8'h02;
    bus_read(B + 32'h10, rd); check("sw_sync0", rd, 32'h0);
    tick(); bus_read(B + 32'h10, rd); check("sw_sync1", rd, 32'h0);
    tick(); bus_read(B + 32'h10, rd); check("sw_sync2", rd, 32'h02);

    // EN freeze and resume with TL = 0xBEEF
    bus_write(B + 32'h08, 32'h1);
    repeat (3) tick();
    bus_read(B + 32'h04, rd); check("tl_count", rd, 32'h0000_BEF2);
    bus_write(B + 32'h08, 32'h0);
    repeat (3) tick();
    bus_read(B + 32'h04, rd); check("tl_frozen", rd, 32'h0000_BEF3);
    bus_write(B + 32'h08, 32'h1);
    tick();
    bus_read(B + 32'h04, rd); check("tl_resume", rd, 32'h0000_BEF4);
    bus_write(B + 32'h08, 32'h0);

    // Reload and irq
    bus_write(B + 32'h00, 32'hFFFF_FFFC);
    bus_write(B + 32'h04, 32'hFFFF_FFFE);
    bus_write(B + 32'h08, 32'h3);
    bus_read(B + 32'h04, rd); check("tl_start", rd, 32'hFFFF_FFFE);
    tick();
    bus_read(B + 32'h04, rd); check("tl_max", rd, 32'hFFFF_FFFF);
    check("irq_pre", {31'd0, irq}, 32'h0);
    tick();
    bus_read(B + 32'h04, rd); check("tl_reload", rd, 32'hFFFF_FFFC);
    check("irq_ovf", {31'd0, irq}, 32'h1);
    bus_write(B + 32'h08, 32'h3);
    check("irq_cleared", {31'd0, irq}, 32'h0);
    n = 0;
    while (!irq && n < 10) begin
      tick();
      n++;
    end
    check("ovf_period", n, 3);

    // TCON=3 write landing on the overflow cycle keeps ST set
    bus_write(B + 32'h08, 32'h3);
    check("irq_clr2", {31'd0, irq}, 32'h0);
    repeat (2) tick();
    bus_read(B + 32'h04, rd); check("tl_pre_col1", rd, 32'hFFFF_FFFF);
    bus_write(B + 32'h08, 32'h3);
    check("col_tcon_irq", {31'd0, irq}, 32'h1);
    bus_read(B + 32'h08, rd); check("col_tcon_st", rd, 32'h7);

    // TL write landing on the overflow cycle wins; no overflow recorded
    bus_write(B + 32'h08, 32'h3);
    repeat (2) tick();
    bus_read(B + 32'h04, rd); check("tl_pre_col2", rd, 32'hFFFF_FFFF);
    bus_write(B + 32'h04, 32'h5);
    bus_read(B + 32'h04, rd); check("col_tl_val", rd, 32'h5);
    check("col_tl_irq", {31'd0, irq}, 32'h0);
    tick();
    bus_read(B + 32'h04, rd); check("tl_after_col", rd, 32'h6);

`ifdef SCMIPS_SYSTICK_EN
    bus_read(B + 32'h18, rd);
    repeat (10) tick();
    bus_read(B + 32'h18, rd2);
    check("systick_delta", rd2 - rd, 32'd10);
`else
    bus_read(B + 32'h18, rd); check("systick_off", rd, 32'h0);
    rd2 = rd;
`endif

    // Reset while counting with irq high
    bus_write(B + 32'h04, 32'hFFFF_FFFF);
    tick();
    check("irq_before_rst", {31'd0, irq}, 32'h1);
    reset = 1'b1;
    tick();
    check("rst_mid_irq", {31'd0, irq}, 32'h0);
    check("rst_mid_led", {24'd0, led}, 32'h0);
    check("rst_mid_dig1", {25'd0, digi_out1}, 32'h40);
    reset = 1'b0;
    bus_read(B + 32'h04, rd); check("rst_mid_tl", rd, 32'h0);
    bus_read(B + 32'h00, rd); check("rst_mid_th", rd, 32'h0);
    bus_read(B + 32'h08, rd); check("rst_mid_tcon", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
